ram_nbuf_wrapper: RTL and testbench

RAM_NBUF_WRAPPER -- requirements
Module: ram_nbuf_wrapper

---
 rtl/ram_nbuf_wrapper.sv | 147 ++++++++++++++
 tb/tb_ram_nbuf_wrapper.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_nbuf_wrapper.sv
// rtl/ram_nbuf_wrapper.sv - N-buffered SRAM ring between a narrow host port and a wide accelerator port
// The host fills bank hp and commits it; the accelerator drains bank ap and releases it.
module ram_nbuf_wrapper #(
  parameter  int IF_W   = 32,
  parameter  int SRAM_W = 128,
  parameter  int SRAM_N = 8,
  parameter  int ADR_W  = 10,
  parameter  int NBUF   = 3,
  localparam int HN     = SRAM_W / IF_W,
  localparam int HB     = (HN > 1) ? $clog2(HN) : 0,
  localparam int CW     = $clog2(NBUF + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [ADR_W+HB-1:0]  i_host_addr,
  input  logic [IF_W-1:0]      i_host_data,
  input  logic [IF_W-1:0]      i_host_wmask,
  input  logic                 i_host_wren,
  input  logic                 i_host_rden,
  output logic [IF_W-1:0]      o_host_data,
  output logic                 o_host_rvalid,
  input  logic                 i_host_commit,
  output logic                 o_host_ready,
  input  logic [ADR_W-1:0]     i_acc_addr,
  input  logic [SRAM_W-1:0]    i_acc_data,
  input  logic [SRAM_N-1:0]    i_acc_wmask,
  input  logic                 i_acc_wren,
  input  logic                 i_acc_rden,
  output logic [SRAM_W-1:0]    o_acc_data,
  output logic                 o_acc_rvalid,
  input  logic                 i_acc_release,
  output logic                 o_acc_ready,
  output logic [CW-1:0]        o_count,
  output logic                 o_err
);

  localparam int PW    = $clog2(NBUF);
  localparam int DEPTH = 1 << ADR_W;
  localparam int G     = SRAM_W / SRAM_N;
  localparam int HBW   = (HB > 0) ? HB : 1;
  localparam logic [CW-1:0] NBUF_C = CW'(NBUF);
  localparam logic [PW-1:0] LAST_C = PW'(NBUF - 1);

  logic [SRAM_W-1:0] r_mem [NBUF][DEPTH];

  logic [PW-1:0]     r_hp, r_ap;
  logic [CW-1:0]     r_count;
  logic              r_err;
  logic              r_host_rvalid, r_acc_rvalid;
  logic [IF_W-1:0]   r_host_data;
  logic [SRAM_W-1:0] r_acc_data;

  logic [ADR_W-1:0]  w_host_row;
  logic [HBW-1:0]    w_host_word;
  logic [SRAM_W-1:0] w_host_wdata, w_host_bmask, w_acc_bmask, w_host_rrow;
  logic [IF_W-1:0]   w_host_rword;
  logic              w_host_ok, w_acc_ok;
  logic              w_hwr, w_hrd, w_awr, w_ard, w_commit, w_release;
  logic              w_host_bad, w_acc_bad;

  assign w_host_row = i_host_addr[ADR_W+HB-1:HB];

  generate
    if (HB > 0) begin : g_word
      assign w_host_word = i_host_addr[HBW-1:0];
    end else begin : g_noword
      assign w_host_word = '0;
    end
  endgenerate

  assign w_host_ok  = (r_count < NBUF_C);
  assign w_acc_ok   = (r_count != '0);
  assign w_hwr      = i_host_wren & w_host_ok;
  assign w_hrd      = i_host_rden & w_host_ok;
  assign w_commit   = i_host_commit & w_host_ok;
  assign w_awr      = i_acc_wren & w_acc_ok;
  assign w_ard      = i_acc_rden & w_acc_ok;
  assign w_release  = i_acc_release & w_acc_ok;
  assign w_host_bad = ~w_host_ok & (i_host_wren | i_host_rden | i_host_commit);
  assign w_acc_bad  = ~w_acc_ok & (i_acc_wren | i_acc_rden | i_acc_release);

  assign w_host_wdata = {HN{i_host_data}};
  assign w_host_rrow  = r_mem[r_hp][w_host_row];

  // Host mask lands only on the addressed word; acc granule mask fans out to bit level.
  always_comb begin
    w_host_bmask = '0;
    w_host_rword = w_host_rrow[IF_W-1:0];
    for (int i = 0; i < HN; i++) begin
      if (HBW'(i) == w_host_word) begin
        w_host_bmask[i*IF_W +: IF_W] = i_host_wmask;
        w_host_rword                 = w_host_rrow[i*IF_W +: IF_W];
      end
    end
    for (int j = 0; j < SRAM_N; j++) begin
      w_acc_bmask[j*G +: G] = {G{i_acc_wmask[j]}};
    end
  end

  // hp and ap never point at the same bank while both sides are allowed to access.
  always_ff @(posedge i_clk) begin
    if (w_hwr) begin
      r_mem[r_hp][w_host_row] <= (r_mem[r_hp][w_host_row] & ~w_host_bmask) |
                                 (w_host_wdata & w_host_bmask);
    end
    if (w_awr) begin
      r_mem[r_ap][i_acc_addr] <= (r_mem[r_ap][i_acc_addr] & ~w_acc_bmask) |
                                 (i_acc_data & w_acc_bmask);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_hp          <= '0;
      r_ap          <= '0;
      r_count       <= '0;
      r_err         <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_acc_rvalid  <= 1'b0;
      r_host_data   <= '0;
      r_acc_data    <= '0;
    end else begin
      r_host_rvalid <= w_hrd;
      r_acc_rvalid  <= w_ard;
      if (w_hrd) r_host_data <= w_host_rword;
      if (w_ard) r_acc_data  <= r_mem[r_ap][i_acc_addr];
      r_err <= r_err | w_host_bad | w_acc_bad;
      if (w_commit)  r_hp <= (r_hp == LAST_C) ? '0 : r_hp + 1'b1;
      if (w_release) r_ap <= (r_ap == LAST_C) ? '0 : r_ap + 1'b1;
      case ({w_commit, w_release})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_host_data   = r_host_data;
  assign o_host_rvalid = r_host_rvalid;
  assign o_acc_data    = r_acc_data;
  assign o_acc_rvalid  = r_acc_rvalid;
  assign o_host_ready  = w_host_ok;
  assign o_acc_ready   = w_acc_ok;
  assign o_count       = r_count;
  assign o_err         = r_err;

endmodule

// File: tb/tb_ram_nbuf_wrapper.sv
// tb/tb_ram_nbuf_wrapper.sv - self-checking bench for ram_nbuf_wrapper
// A ring-buffer model with bit-known masks is compared every cycle; directed scenarios add literal checks.
module tb_ram_nbuf_wrapper;

  localparam int IF_W = 32, SRAM_W = 128, SRAM_N = 8, ADR_W = 10, NBUF = 3;
  localparam int HN = 4, HB = 2, CW = 2, DEPTH = 1024, G = 16;

  logic              i_clk, i_rstn;
  logic [ADR_W+HB-1:0] i_host_addr;
  logic [IF_W-1:0]   i_host_data, i_host_wmask, o_host_data;
  logic              i_host_wren, i_host_rden, o_host_rvalid, i_host_commit, o_host_ready;
  logic [ADR_W-1:0]  i_acc_addr;
  logic [SRAM_W-1:0] i_acc_data, o_acc_data;
  logic [SRAM_N-1:0] i_acc_wmask;
  logic              i_acc_wren, i_acc_rden, o_acc_rvalid, i_acc_release, o_acc_ready;
  logic [CW-1:0]     o_count;
  logic              o_err;

  ram_nbuf_wrapper #(.IF_W(IF_W), .SRAM_W(SRAM_W), .SRAM_N(SRAM_N), .ADR_W(ADR_W), .NBUF(NBUF)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_host_addr(i_host_addr), .i_host_data(i_host_data), .i_host_wmask(i_host_wmask),
    .i_host_wren(i_host_wren), .i_host_rden(i_host_rden),
    .o_host_data(o_host_data), .o_host_rvalid(o_host_rvalid),
    .i_host_commit(i_host_commit), .o_host_ready(o_host_ready),
    .i_acc_addr(i_acc_addr), .i_acc_data(i_acc_data), .i_acc_wmask(i_acc_wmask),
    .i_acc_wren(i_acc_wren), .i_acc_rden(i_acc_rden),
    .o_acc_data(o_acc_data), .o_acc_rvalid(o_acc_rvalid),
    .i_acc_release(i_acc_release), .o_acc_ready(o_acc_ready),
    .o_count(o_count), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_fail = 0;

  task automatic chkm(input string nm, input logic [127:0] act, input logic [127:0] exp,
                      input logic [127:0] msk);
    n_chk++;
    if (((act ^ exp) & msk) != 128'h0) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act & msk, exp & msk);
    end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    chkm(nm, act, exp, {128{1'b1}});
  endtask

  // Model: banks as plain arrays, known-bit masks for contents never written.
  logic [SRAM_W-1:0] mm [NBUF][DEPTH];
  logic [SRAM_W-1:0] mk [NBUF][DEPTH];
  int m_hp, m_ap, m_count;
  bit m_err, m_hrv, m_arv;
  logic [IF_W-1:0]   m_hdata, m_hknown;
  logic [SRAM_W-1:0] m_adata, m_aknown;

  always @(posedge i_clk) begin
    bit hok, aok, c, r;
    int row, word;
    if (!i_rstn) begin
      m_hp = 0; m_ap = 0; m_count = 0; m_err = 0; m_hrv = 0; m_arv = 0;
      m_hdata = '0; m_hknown = '1; m_adata = '0; m_aknown = '1;
      for (int b = 0; b < NBUF; b++)
        for (int a = 0; a < DEPTH; a++) mk[b][a] = '0;
    end else begin
      hok = (m_count < NBUF);
      aok = (m_count > 0);
      row = int'(i_host_addr) / HN;
      word = int'(i_host_addr) % HN;
      m_hrv = 0;
      m_arv = 0;
      if (i_host_rden) begin
        if (hok) begin
          m_hrv = 1;
          m_hdata = mm[m_hp][row][word*IF_W +: IF_W];
          m_hknown = i_host_wren ? '0 : mk[m_hp][row][word*IF_W +: IF_W];
        end else m_err = 1;
      end
      if (i_acc_rden) begin
        if (aok) begin
          m_arv = 1;
          m_adata = mm[m_ap][i_acc_addr];
          m_aknown = i_acc_wren ? '0 : mk[m_ap][i_acc_addr];
        end else m_err = 1;
      end
      if (i_host_wren) begin
        if (hok) begin
          for (int k = 0; k < IF_W; k++)
            if (i_host_wmask[k]) begin
              mm[m_hp][row][word*IF_W + k] = i_host_data[k];
              mk[m_hp][row][word*IF_W + k] = 1'b1;
            end
        end else m_err = 1;
      end
      if (i_acc_wren) begin
        if (aok) begin
          for (int k = 0; k < SRAM_W; k++)
            if (i_acc_wmask[k / G]) begin
              mm[m_ap][i_acc_addr][k] = i_acc_data[k];
              mk[m_ap][i_acc_addr][k] = 1'b1;
            end
        end else m_err = 1;
      end
      c = i_host_commit & hok;
      r = i_acc_release & aok;
      if (i_host_commit & !hok) m_err = 1;
      if (i_acc_release & !aok) m_err = 1;
      if (c) m_hp = (m_hp + 1) % NBUF;
      if (r) m_ap = (m_ap + 1) % NBUF;
      m_count = m_count + int'(c) - int'(r);
    end
  end

  always @(negedge i_clk) begin
    if (!i_rstn) begin
      chk("rst_count", o_count, 0);
      chk("rst_host_ready", o_host_ready, 1);
      chk("rst_acc_ready", o_acc_ready, 0);
      chk("rst_err", o_err, 0);
      chk("rst_host_rvalid", o_host_rvalid, 0);
      chk("rst_acc_rvalid", o_acc_rvalid, 0);
      chk("rst_host_data", o_host_data, 0);
      chk("rst_acc_data", o_acc_data, 0);
    end else begin
      chk("count", o_count, m_count);
      chk("host_ready", o_host_ready, m_count < NBUF);
      chk("acc_ready", o_acc_ready, m_count > 0);
      chk("err", o_err, m_err);
      chk("host_rvalid", o_host_rvalid, m_hrv);
      chk("acc_rvalid", o_acc_rvalid, m_arv);
      chkm("host_data", o_host_data, m_hdata, m_hknown);
      chkm("acc_data", o_acc_data, m_adata, m_aknown);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    i_host_wren = 0; i_host_rden = 0; i_host_commit = 0;
    i_acc_wren = 0; i_acc_rden = 0; i_acc_release = 0;
  endtask

  task automatic do_reset();
    i_rstn = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1;
  endtask

  initial begin
    i_rstn = 0;
    i_host_addr = '0; i_host_data = '0; i_host_wmask = '0;
    i_host_wren = 0; i_host_rden = 0; i_host_commit = 0;
    i_acc_addr = '0; i_acc_data = '0; i_acc_wmask = '0;
    i_acc_wren = 0; i_acc_rden = 0; i_acc_release = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("lit_rst_host_ready", o_host_ready, 1);
    chk("lit_rst_acc_ready", o_acc_ready, 0);
    chk("lit_rst_count", o_count, 0);
    i_rstn = 1;

    // Host word write, read-back, commit, accelerator sees it in its row
    i_host_addr = 12'd5; i_host_data = 32'hA5A5A5A5; i_host_wmask = '1; i_host_wren = 1; tick();
    i_host_rden = 1; tick();
    chk("lit_host_rd", o_host_data, 32'hA5A5A5A5);
    chk("lit_host_rvalid", o_host_rvalid, 1);
    i_host_commit = 1; tick();
    chk("lit_count1", o_count, 1);
    i_acc_addr = 10'd1; i_acc_rden = 1; tick();
    chk("lit_acc_rvalid", o_acc_rvalid, 1);
    chk("lit_acc_word1", o_acc_data[63:32], 32'hA5A5A5A5);
    tick();
    chk("lit_acc_rvalid_low", o_acc_rvalid, 0);
    chk("lit_acc_hold", o_acc_data[63:32], 32'hA5A5A5A5);

    // Granule masks: clear row, set granule 0, then a zero-mask write
    i_acc_addr = 10'd2; i_acc_data = '0; i_acc_wmask = 8'hFF; i_acc_wren = 1; tick();
    i_acc_data = '1; i_acc_wmask = 8'h01; i_acc_wren = 1; tick();
    i_acc_wmask = 8'h00; i_acc_wren = 1; tick();
    i_acc_rden = 1; tick();
    chk("lit_acc_gran0", o_acc_data, {112'h0, 16'hFFFF});

    // Simultaneous commit and release at count 1
    i_host_addr = 12'd0; i_host_data = 32'h11111111; i_host_wren = 1; tick();
    i_host_commit = 1; i_acc_release = 1; tick();
    chk("lit_count_same", o_count, 1);
    i_acc_addr = 10'd0; i_acc_rden = 1; tick();
    chk("lit_ap_adv", o_acc_data[31:0], 32'h11111111);
    i_host_addr = 12'd4; i_host_data = 32'h22222222; i_host_wren = 1; tick();
    i_host_commit = 1; tick();
    i_acc_release = 1; tick();
    i_acc_addr = 10'd1; i_acc_rden = 1; tick();
    chk("lit_hp_adv", o_acc_data[31:0], 32'h22222222);

    // Fill to NBUF, then overflow commit
    i_host_commit = 1; tick();
    i_host_commit = 1; tick();
    chk("lit_full_count", o_count, 3);
    chk("lit_full_ready", o_host_ready, 0);
    chk("lit_full_err", o_err, 0);
    i_host_commit = 1; i_host_wren = 1; tick();
    chk("lit_ovf_err", o_err, 1);
    chk("lit_ovf_count", o_count, 3);

    // Pointer wrap from a fresh reset
    do_reset();
    for (int b = 0; b < NBUF; b++) begin
      i_host_addr = 12'd8; i_host_data = 32'hB0 + b; i_host_wren = 1; tick();
      i_host_commit = 1; tick();
    end
    for (int b = 0; b < NBUF; b++) begin
      i_acc_addr = 10'd2; i_acc_rden = 1; tick();
      chk("lit_wrap_tag", o_acc_data[31:0], 32'hB0 + b);
      i_acc_release = 1; tick();
    end
    chk("lit_wrap_count", o_count, 0);
    chk("lit_wrap_err", o_err, 0);
    i_host_addr = 12'd8; i_host_data = 32'hCAFE0000; i_host_wren = 1; tick();
    i_host_commit = 1; tick();
    i_acc_rden = 1; tick();
    chk("lit_wrap_bank0", o_acc_data[31:0], 32'hCAFE0000);

    // Reset with an accelerator read pending
    i_acc_rden = 1;
    #2;
    i_rstn = 0;
    @(posedge i_clk);
    #1;
    i_acc_rden = 0;
    chk("lit_abort_rvalid", o_acc_rvalid, 0);
    chk("lit_abort_data", o_acc_data, 0);
    chk("lit_abort_acc_ready", o_acc_ready, 0);
    i_rstn = 1;
    tick();
    chk("lit_abort_rvalid2", o_acc_rvalid, 0);
    chk("lit_abort_count", o_count, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
